// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Fall-through response buffer: an entry pushed into an empty FIFO is visible
// on the output in the same cycle and bypasses storage if popped immediately.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          Rst,
  input  logic          push_i,
  input  imem_rsp_t     push_data_i,
  output logic          pop_valid_o,
  output imem_rsp_t     pop_data_o,
  input  logic          pop_ready_i,
  output logic [CW-1:0] count_o
);

  imem_rsp_t     mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty;
  logic          bypass;
  logic          wr_en;
  logic          rd_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (count_q == '0);
  assign pop_valid_o = !empty || push_i;
  assign pop_data_o  = empty ? push_data_i : mem_q[rd_q];
  assign count_o     = count_q;

  // Empty + push + pop: the entry passes straight through and is never stored.
  assign bypass = empty && push_i && pop_ready_i;
  assign wr_en  = push_i && !bypass;
  assign rd_en  = pop_valid_o && pop_ready_i && !empty;

  always_comb begin
    rd_d    = rd_en ? ptr_inc(rd_q) : rd_q;
    wr_d    = wr_en ? ptr_inc(wr_q) : wr_q;
    count_d = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clock) begin
    if (Rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  a_no_overflow : assert property (@(posedge clock) disable iff (Rst)
    !(wr_en && !rd_en && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/imem_responder.sv
// Memory side of the instruction-fetch interface: fixed-latency read pipeline
// feeding an in-order response FIFO, with credit-based request flow control.
module imem_responder
  import imem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  parameter  int unsigned LATENCY     = 2,
  parameter  int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned IW          = $clog2(DEPTH_WORDS),
  localparam int unsigned OW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          Rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_err,
  input  logic          load_en,
  input  logic [IW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  logic [31:0]   store_q [DEPTH_WORDS];
  logic [IW-1:0] req_idx;
  logic          addr_err;
  logic          req_fire;
  logic          rsp_fire;
  imem_rsp_t     stage0_d;

  logic [LATENCY-1:0] pipe_v_q;
  imem_rsp_t          pipe_q [LATENCY];

  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] inflight;

  logic          fifo_valid;
  imem_rsp_t     fifo_data;
  logic [OW-1:0] fifo_count;

  // Store is deliberately not reset so loaded programs survive a core reset.
  always_ff @(posedge clock) begin
    if (load_en) begin
      store_q[load_addr] <= load_data;
    end
  end

  assign req_idx  = req_addr[IW+1:2];
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:IW+2] != '0);
  assign req_ready = (outstanding_q < OW'(FIFO_DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = fifo_valid && rsp_ready;

  // Combinational read at accept sees the pre-write word: read-first for free.
  always_comb begin
    stage0_d.err  = addr_err;
    stage0_d.data = addr_err ? NOP_INSN : store_q[req_idx];
  end

  always_ff @(posedge clock) begin
    if (Rst) begin
      pipe_v_q <= '0;
    end else begin
      pipe_v_q[0] <= req_fire;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_v_q[k] <= pipe_v_q[k-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    pipe_q[0] <= stage0_d;
    for (int k = 1; k < LATENCY; k++) begin
      pipe_q[k] <= pipe_q[k-1];
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({req_fire, rsp_fire})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Rst) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  imem_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clock       (clock),
    .Rst         (Rst),
    .push_i      (pipe_v_q[LATENCY-1]),
    .push_data_i (pipe_q[LATENCY-1]),
    .pop_valid_o (fifo_valid),
    .pop_data_o  (fifo_data),
    .pop_ready_i (rsp_ready),
    .count_o     (fifo_count)
  );

  assign rsp_valid = fifo_valid;
  assign rsp_data  = fifo_valid ? fifo_data.data : '0;
  assign rsp_err   = fifo_valid && fifo_data.err;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LATENCY; k++) begin
      inflight = inflight + OW'(pipe_v_q[k]);
    end
  end

  a_credit_consistent : assert property (@(posedge clock) disable iff (Rst)
    outstanding_q == (inflight + fifo_count));

  a_credit_range : assert property (@(posedge clock) disable iff (Rst)
    outstanding_q <= OW'(FIFO_DEPTH));

endmodule
